serial_bus_master: RTL
======================

# serial_bus_master

Parametrised serial-link bus master for the Microzed-to-Spartan6/Artix7 ad-hoc serial protocol. It accepts one register read or write request at a time over a valid/ready handshake and serialises it as framed 9-bit "bytes" on a single wire. It then deframes the slave's reply into read data and status, with a timeout if no reply arrives. It replaces the fixed 16/16-bit shift-out/shift-in logic in the PL top level and is sized by parameters.

## Interface
- ADDR_W, 16: address width; multiple of 8, range 8..32.
- DATA_W, 16: data width; multiple of 8, range 8..32.
- TIMEOUT, 4096: WAIT-state cycle limit; 0 disables the timeout.
- clk  in  1  system clock (fclk0 domain); all logic is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request transfers when req_valid && req_ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  register address.
- req_wrdata  in  DATA_W  write data; ignored for reads.
- resp_valid  out  1  one-cycle pulse on completion.
- resp_rddata  out  DATA_W  data bytes of the last reply.
- resp_status  out  8  status byte of the last reply.
- resp_timeout  out  1  the last completion was a timeout.
- busy  out  1  high whenever the FSM is not IDLE.
- ser_out  out  1  serial line to the slave (registered).
- ser_in  in  1  serial line from the slave.
- bytes_sent  out  16  frames transmitted.
- bytes_seen  out  16  frames received.

## Operation
- Reset values: all outputs 0 except req_ready = 1. All internal registers are 0.
- Frame: 13 bits, sent MSB first: 0, 1, C, D[7:0], 0, 0.
  - C = 1 marks a command/status byte.
  - C = 0 marks a data/address byte.
- Write request frames, in order:
  - req_wrdata bytes, most significant byte first.
  - req_addr bytes, most significant byte first.
  - Command frame C=1, D=8'h01.
  - Total DATA_W/8 + ADDR_W/8 + 1 frames.
- Read request frames, in order:
  - req_addr bytes, most significant byte first.
  - Command frame C=1, D=8'h02.
  - Total ADDR_W/8 + 1 frames.
- Frames are sent back-to-back with no gap. ser_out = 0 whenever no frame is being sent.
- FSM states:
  - IDLE: leaves to SEND on handshake; captures wr, addr and data.
  - SEND: shifts one bit per clock; after the last bit goes to WAIT.
  - WAIT: waits for a reply.
  - DONE: lasts 1 cycle, pulses resp_valid, returns to IDLE.
- Receiver:
  - ser_in passes through a 2-flop synchroniser into a 12-bit shift register sr.
  - A frame is recognised when sr[11]=1 and sr[1:0]=00.
  - On recognition, sr clears to 0, bytes_seen increments, and sr[9:2] shifts into a (DATA_W+8)-bit byte history.
  - If sr[10]=1, the frame is a status frame.
  - The receiver runs in every state.
- Completion in WAIT on a status frame:
  - resp_status = status byte.
  - resp_rddata = the DATA_W/8 bytes received before it, earliest byte = MSB.
  - resp_timeout = 0.
  - The byte history clears.
- Status frames received outside WAIT are counted and clear the history, but produce no response.
- Timeout: after TIMEOUT cycles in WAIT with no status frame, go to DONE with resp_timeout = 1, resp_status = 8'hFF, resp_rddata = 0.
- A status frame on the same cycle as timeout expiry counts as a normal reply.
- Response outputs hold their values until the next completion.
- Counters: bytes_sent increments by 1 as each frame's first bit is launched. Both counters are 16 bits and wrap at 16'hFFFF to 0.
- If rst_n is asserted mid-operation, all state clears immediately: ser_out = 0, the FSM goes to IDLE, and any partial frame is discarded.

## Timing
- Handshake edge k: ser_out carries frame bit 0 at k+1 and bit 1 (the 1) at k+2.
- A write with default widths occupies ser_out for 5×13 = 65 cycles, k+1..k+65; WAIT begins at k+66.
- A read with default widths occupies ser_out for 3×13 = 39 cycles.
- Receive path:
  - The last bit of a status frame is on ser_in at cycle r.
  - It reaches sr at r+3 (2 synchroniser flops plus the shift).
  - It is recognised during r+3.
  - The FSM is in DONE with resp_valid = 1 at r+4.
  - req_ready = 1 again at r+5.
- req_ready = 0 from the handshake edge through the DONE cycle. Back-to-back requests are therefore spaced by at least the frame time plus the reply time plus 2 cycles.
- Timeout: resp_valid is asserted TIMEOUT+1 cycles after WAIT entry.

## Test plan
- Write, addr 16'h0003, data 16'h1234, default widths:
  - ser_out carries 65 bits: 0,1,0,0x12,00 / 0,1,0,0x34,00 / 0,1,0,0x00,00 / 0,1,0,0x03,00 / 0,1,1,0x01,00.
  - bytes_sent = 5.
- Read, addr 16'h0001, loopback fake slave replying 0xBE, 0xEF, then status 0x00 with C=1:
  - resp_valid pulses once; resp_rddata = 16'hBEEF, resp_status = 8'h00, resp_timeout = 0.
  - bytes_seen = 3.
- Read with ser_in held at 0 and TIMEOUT = 100:
  - resp_valid pulses 101 cycles after WAIT entry; resp_timeout = 1, resp_status = 8'hFF, resp_rddata = 0.
- Stray status frame injected while IDLE:
  - No resp_valid; bytes_seen increments by 1.
  - A following read returns correct data, unaffected by the stray frame.
- rst_n pulsed low at bit 30 of a write:
  - ser_out = 0 and req_ready = 1 immediately; counters = 0.
  - The next write transmits a complete, correct frame sequence.
- Parameter sweep ADDR_W=32, DATA_W=32, write 32'hDEADBEEF to 32'h00000210:
  - 9 frames sent; a loopback read of the same address returns 32'hDEADBEEF.

Source files
------------

// File: rtl/serial_bus_master.sv
// Serial-link bus master: frames one register read/write request onto ser_out
// as 13-bit frames and deframes the slave's reply (data bytes + status) from ser_in.
module serial_bus_master #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wrdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rddata,
  output logic [7:0]        resp_status,
  output logic              resp_timeout,
  output logic              busy,
  output logic              ser_out,
  input  logic              ser_in,
  output logic [15:0]       bytes_sent,
  output logic [15:0]       bytes_seen
);
  localparam int NA = ADDR_W / 8;
  localparam int ND = DATA_W / 8;
  localparam int PW = ADDR_W + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t            state_r, state_next_s;
  logic [PW-1:0]     payload_r;
  logic              is_wr_r;
  logic [3:0]        n_frames_r, frame_idx_r, bit_idx_r;
  logic [31:0]       wait_cnt_r;
  logic              ser_out_r, sync1_r, sync2_r;
  logic [11:0]       sr_r;
  logic [DATA_W-1:0] hist_r;
  logic [15:0]       bytes_sent_r, bytes_seen_r;
  logic              req_ready_r, busy_r, resp_valid_r, resp_timeout_r;
  logic [DATA_W-1:0] resp_rddata_r;
  logic [7:0]        resp_status_r;

  logic              handshake_s, send_done_s, cmd_frame_s, tx_bit_s;
  logic [7:0]        tx_byte_s;
  logic [12:0]       tx_frame_s;
  logic              frame_rx_s, status_rx_s, expire_s;
  logic [DATA_W+7:0] hist_next_s;

  // Transmit bit selection and receive-side frame decode.
  always_comb begin
    handshake_s = req_valid && req_ready_r;
    send_done_s = (frame_idx_r == n_frames_r);
    cmd_frame_s = (frame_idx_r == (n_frames_r - 4'd1));
    if (cmd_frame_s) begin
      tx_byte_s = is_wr_r ? 8'h01 : 8'h02;
    end else begin
      tx_byte_s = payload_r[PW-1 -: 8];
    end
    tx_frame_s  = {1'b0, 1'b1, cmd_frame_s, tx_byte_s, 2'b00};
    tx_bit_s    = tx_frame_s[4'd12 - bit_idx_r];
    // The leading 0 of a frame has already dropped off the 12-bit window.
    frame_rx_s  = sr_r[11] && (sr_r[1:0] == 2'b00);
    status_rx_s = frame_rx_s && sr_r[10];
    expire_s    = (TIMEOUT != 0) && (wait_cnt_r == 32'(TIMEOUT));
    hist_next_s = {hist_r, sr_r[9:2]};
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (handshake_s) state_next_s = S_SEND;
        else             state_next_s = S_IDLE;
      end
      S_SEND: begin
        if (send_done_s) state_next_s = S_WAIT;
        else             state_next_s = S_SEND;
      end
      S_WAIT: begin
        if (status_rx_s || expire_s) state_next_s = S_DONE;
        else                         state_next_s = S_WAIT;
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_next_s;
  end

  // Request capture, frame/bit sequencing, serial output and wait timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload_r    <= {PW{1'b0}};
      is_wr_r      <= 1'b0;
      n_frames_r   <= 4'd0;
      frame_idx_r  <= 4'd0;
      bit_idx_r    <= 4'd0;
      ser_out_r    <= 1'b0;
      bytes_sent_r <= 16'd0;
      wait_cnt_r   <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          ser_out_r <= 1'b0;
          if (handshake_s) begin
            is_wr_r     <= req_wr;
            payload_r   <= req_wr ? {req_wrdata, req_addr} : {req_addr, {DATA_W{1'b0}}};
            n_frames_r  <= req_wr ? 4'(ND + NA + 1) : 4'(NA + 1);
            frame_idx_r <= 4'd0;
            bit_idx_r   <= 4'd0;
          end
        end
        S_SEND: begin
          if (send_done_s) begin
            ser_out_r <= 1'b0;
          end else begin
            ser_out_r <= tx_bit_s;
            if (bit_idx_r == 4'd0) bytes_sent_r <= bytes_sent_r + 16'd1;
            if (bit_idx_r == 4'd12) begin
              bit_idx_r   <= 4'd0;
              frame_idx_r <= frame_idx_r + 4'd1;
              payload_r   <= {payload_r[PW-9:0], 8'h00};
            end else begin
              bit_idx_r <= bit_idx_r + 4'd1;
            end
          end
        end
        default: ser_out_r <= 1'b0;
      endcase
      wait_cnt_r <= (state_r == S_WAIT) ? wait_cnt_r + 32'd1 : 32'd0;
    end
  end

  // Receiver: synchroniser, deframing shift register and byte history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      sr_r         <= 12'd0;
      hist_r       <= {DATA_W{1'b0}};
      bytes_seen_r <= 16'd0;
    end else begin
      sync1_r <= ser_in;
      sync2_r <= sync1_r;
      if (frame_rx_s) begin
        sr_r         <= 12'd0;
        bytes_seen_r <= bytes_seen_r + 16'd1;
        if (sr_r[10]) hist_r <= {DATA_W{1'b0}};
        else          hist_r <= hist_next_s[DATA_W-1:0];
      end else begin
        sr_r <= {sr_r[10:0], sync2_r};
      end
    end
  end

  // Registered handshake/status outputs and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r    <= 1'b1;
      busy_r         <= 1'b0;
      resp_valid_r   <= 1'b0;
      resp_timeout_r <= 1'b0;
      resp_rddata_r  <= {DATA_W{1'b0}};
      resp_status_r  <= 8'h00;
    end else begin
      req_ready_r  <= (state_next_s == S_IDLE);
      busy_r       <= (state_next_s != S_IDLE);
      resp_valid_r <= (state_r == S_WAIT) && (state_next_s == S_DONE);
      if ((state_r == S_WAIT) && status_rx_s) begin
        resp_rddata_r  <= hist_next_s[DATA_W+7:8];
        resp_status_r  <= hist_next_s[7:0];
        resp_timeout_r <= 1'b0;
      end else if ((state_r == S_WAIT) && expire_s) begin
        resp_rddata_r  <= {DATA_W{1'b0}};
        resp_status_r  <= 8'hFF;
        resp_timeout_r <= 1'b1;
      end
    end
  end

  assign req_ready    = req_ready_r;
  assign busy         = busy_r;
  assign resp_valid   = resp_valid_r;
  assign resp_rddata  = resp_rddata_r;
  assign resp_status  = resp_status_r;
  assign resp_timeout = resp_timeout_r;
  assign ser_out      = ser_out_r;
  assign bytes_sent   = bytes_sent_r;
  assign bytes_seen   = bytes_seen_r;
endmodule
